// File: rtl/cd_rx_page_reader_if.sv
// cd_rx_page_reader_if: page-buffer read port plus the downstream byte stream.
// master is the reader side; slave is the buffer/consumer side.
interface cd_rx_page_reader_if #(
    parameter int A_WIDTH = 8
);
    logic [A_WIDTH-1:0] rd_addr;
    logic               rd_en;
    logic [7:0]         rd_byte;
    logic [7:0]         m_data;
    logic               m_valid;
    logic               m_ready;
    logic               m_last;

    modport master (
        output rd_addr, rd_en, m_data, m_valid, m_last,
        input  rd_byte, m_ready
    );

    modport slave (
        input  rd_addr, rd_en, m_data, m_valid, m_last,
        output rd_byte, m_ready
    );
endinterface

// File: rtl/cd_rx_page_reader.sv
// cd_rx_page_reader: fetches the length of each committed page, streams the frame
// over valid/ready and retires the page with a single rd_done pulse.
module cd_rx_page_reader #(
    parameter int A_WIDTH  = 8,
    parameter int LEN_OFS  = 2,
    parameter int HDR_LEN  = 3,
    parameter int MAX_DATA = 253
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic unread,
    input  logic abort,
    input  logic flush,
    output logic rd_done,
    output logic rd_done_all,
    output logic busy,
    output logic len_err,
    cd_rx_page_reader_if.master bus
);
    localparam logic [A_WIDTH-1:0] LEN_ADDR = A_WIDTH'(LEN_OFS);
    localparam logic [A_WIDTH:0]   HDR_W    = (A_WIDTH+1)'(HDR_LEN);
    localparam logic [7:0]         MAX_B    = 8'(MAX_DATA);

    typedef enum logic [2:0] {IDLE, LEN_RD, LEN_CAP, DAT_RD, DAT_LD, DAT_OUT} state_t;

    state_t             state_q, state_d;
    logic [A_WIDTH:0]   idx_q, idx_d, total_q, total_d;
    logic [A_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]         m_data_q, m_data_d;
    logic               m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic               len_bad, keep;

    assign len_bad = bus.rd_byte > MAX_B;
    // flush wins over abort, abort over normal progression
    assign keep    = !flush && !(abort && state_q != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            total_q   <= '0;
            addr_q    <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            total_q   <= total_d;
            addr_q    <= addr_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en && unread) state_d = LEN_RD;
            LEN_RD:  state_d = LEN_CAP;
            LEN_CAP: state_d = len_bad ? IDLE : DAT_RD;
            DAT_RD:  state_d = DAT_LD;
            DAT_LD:  state_d = DAT_OUT;
            DAT_OUT: if (bus.m_ready) state_d = m_last_q ? IDLE : DAT_RD;
            default: state_d = IDLE;
        endcase
        if (!keep) state_d = IDLE;
    end

    always_comb begin
        busy        = state_q != IDLE;
        bus.rd_en   = state_q == LEN_RD || state_q == DAT_RD;
        addr_d      = state_q == LEN_RD ? LEN_ADDR : state_q == DAT_RD ? idx_q[A_WIDTH-1:0] : addr_q;
        bus.rd_addr = addr_d;
        len_err     = keep && state_q == LEN_CAP && len_bad;
        rd_done     = len_err || (keep && state_q == DAT_OUT && bus.m_ready && m_last_q);
        rd_done_all = flush;
        total_d     = state_q == LEN_CAP ? (A_WIDTH+1)'(bus.rd_byte) + HDR_W : total_q;
        idx_d       = state_q == LEN_CAP ? '0 : (state_q == DAT_OUT && bus.m_ready) ? idx_q + 1'b1 : idx_q;
        m_data_d    = state_q == DAT_LD ? bus.rd_byte : m_data_q;
        // the byte stays presented until the consumer takes it
        m_valid_d   = keep && (state_q == DAT_LD || (state_q == DAT_OUT && !bus.m_ready));
        m_last_d    = keep && (state_q == DAT_LD ? idx_q == total_q - 1'b1
                                                 : state_q == DAT_OUT && !bus.m_ready && m_last_q);
        bus.m_data  = m_data_q;
        bus.m_valid = m_valid_q;
        bus.m_last  = m_last_q;
    end
endmodule
